// File: rtl/serial_tx_frame.sv
// Parametrised serial frame transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, one or two stop bits, each bit held CLKS_PER_BIT clocks.
module serial_tx_frame #(
    parameter int DATA_W       = 7,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid,
    output logic              ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("serial_tx_frame: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("serial_tx_frame: CLKS_PER_BIT must be >= 1");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("serial_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("serial_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state, state_d;
    logic [BAUD_W-1:0]   baud_cnt, baud_d;
    logic [3:0]          bit_cnt, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                line_d;
    logic                last_baud;
    logic                last_stop;
    logic                accept;

    assign last_baud = (baud_cnt == BAUD_LAST);
    assign last_stop = (state == S_STOP) && (bit_cnt == STOP_LAST) && last_baud;
    assign ready     = (state == S_IDLE) || last_stop;
    assign done      = last_stop;
    assign busy      = (state != S_IDLE);
    assign accept    = valid && ready;

    // serial_out is registered, so the line value is derived from the next state.
    always_comb begin
        state_d  = state;
        baud_d   = last_baud ? '0 : baud_cnt + 1'b1;
        bit_d    = bit_cnt;
        shift_d  = shift_q;
        parity_d = parity_q;
        line_d   = 1'b1;

        case (state)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (accept) state_d = S_START;
            end
            S_START: begin
                if (last_baud) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (last_baud) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_cnt + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (last_baud) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (last_baud) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = accept ? S_START : S_IDLE;
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        if (accept) begin
            shift_d  = data_in;
            parity_d = (PARITY == 2) ? ~^data_in : ^data_in;
        end

        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_d[0];
            S_PARITY: line_d = parity_d;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_d;
            baud_cnt   <= baud_d;
            bit_cnt    <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            serial_out <= line_d;
        end
    end

endmodule
